// File: rtl/i2c_ball_pkg.sv
// Shared definitions for the ball hand-off I2C link: receiver states,
// packet size, default address and byte positions within the packet.
package i2c_ball_pkg;

    localparam int         NUM_BYTES          = 6;
    localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'h42;

    localparam int IDX_Y0        = 0;
    localparam int IDX_Y1        = 1;
    localparam int IDX_YVEL      = 2;
    localparam int IDX_GRAVITY   = 3;
    localparam int IDX_BALLSPEED = 4;
    localparam int IDX_WINFLAG   = 5;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_e;

endpackage

// File: rtl/i2c_ball_rx_slave_if.sv
// Pin-side I2C bus of the ball receiver: raw SCL/SDA in, SDA pull-low enable out.
interface i2c_ball_rx_slave_if;

    logic i_scl;
    logic i_sda;
    logic o_sda_low;

    modport master (output i_scl, output i_sda, input  o_sda_low);
    modport slave  (input  i_scl, input  i_sda, output o_sda_low);

endinterface

// File: rtl/i2c_ball_rx_slave_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge and START/STOP detection.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic       scl_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], i_scl};
        sda_sync_d = {sda_sync_q[0], i_sda};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
    end

    // Reset to the idle-bus level so leaving reset never looks like a bus event.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;

    // SCL must be high on both samples so a coincident SCL edge is not a START/STOP.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_ball_rx_slave.sv
// Write-only I2C slave receiving the 6-byte ball hand-off packet; bytes are
// collected in a shadow buffer and committed to the outputs only on a clean STOP.
module i2c_ball_rx_slave #(
    parameter logic [6:0] SLAVE_ADDR = i2c_ball_pkg::SLAVE_ADDR_DEFAULT,
    parameter int         NUM_BYTES  = i2c_ball_pkg::NUM_BYTES
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_ball_rx_slave_if.slave    bus,
    output logic [7:0]            slv_reg0,
    output logic [7:0]            slv_reg1,
    output logic [7:0]            slv_reg2,
    output logic [7:0]            slv_reg3,
    output logic [7:0]            slv_reg4,
    output logic [7:0]            slv_reg5,
    output logic                  is_slave_done,
    output logic                  o_busy,
    output logic                  o_err
);
    import i2c_ball_pkg::*;

    localparam int                CNT_W = $clog2(NUM_BYTES + 1);
    localparam logic [CNT_W-1:0]  NB_C  = CNT_W'(NUM_BYTES);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .i_scl     (bus.i_scl),
        .i_sda     (bus.i_sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]       shadow_q [NUM_BYTES];
    logic [7:0]       shadow_d [NUM_BYTES];
    logic [7:0]       regs_q   [NUM_BYTES];
    logic [7:0]       regs_d   [NUM_BYTES];
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             sda_low_q, sda_low_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       rx_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            shadow_q   <= '{default: '0};
            regs_q     <= '{default: '0};
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            sda_low_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            shadow_q   <= shadow_d;
            regs_q     <= regs_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            sda_low_q  <= sda_low_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        shadow_d   = shadow_q;
        regs_d     = regs_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        sda_low_d  = sda_low_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rx_byte    = {shift_q[6:0], sda_s};

        // Bus conditions override bit handling and drop any ACK drive at once.
        if (start_det) begin
            err_d      = (byte_cnt_q != '0);
            state_d    = ADDR;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            shadow_d   = '{default: '0};
            ovf_d      = 1'b0;
            busy_d     = 1'b0;
            sda_low_d  = 1'b0;
        end else if (stop_det) begin
            if (state_q != IDLE && busy_q) begin
                if (byte_cnt_q == NB_C && !ovf_q) begin
                    regs_d = shadow_q;
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            state_d    = IDLE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            ovf_d      = 1'b0;
            busy_d     = 1'b0;
            sda_low_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    shadow_d   = '{default: '0};
                    ovf_d      = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte == {SLAVE_ADDR, 1'b0}) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                // First SCL fall after the byte starts the ACK, the next one ends it.
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_d = 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = DATA;
                        end
                    end
                end
                DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q < NB_C) begin
                                shadow_d[byte_cnt_q] = rx_byte;
                                byte_cnt_d           = byte_cnt_q + CNT_W'(1);
                                state_d              = DATA_ACK;
                            end else begin
                                ovf_d   = 1'b1;
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                IGNORE: begin
                    sda_low_d = 1'b0;
                end
                default: begin
                    state_d   = IDLE;
                    sda_low_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.o_sda_low  = sda_low_q;
    assign slv_reg0       = regs_q[IDX_Y0];
    assign slv_reg1       = regs_q[IDX_Y1];
    assign slv_reg2       = regs_q[IDX_YVEL];
    assign slv_reg3       = regs_q[IDX_GRAVITY];
    assign slv_reg4       = regs_q[IDX_BALLSPEED];
    assign slv_reg5       = regs_q[IDX_WINFLAG];
    assign is_slave_done  = done_q;
    assign o_busy         = busy_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_i2c_ball_rx_slave.sv
// Bench for the ball receiver: a bit-banged I2C master drives directed and
// random packets; a packet-level model predicts ACKs, committed bytes and pulses.
module tb_i2c_ball_rx_slave;

    localparam int         Q      = 6;
    localparam logic [7:0] ADDR_W = 8'h84;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] regs_o [6];
    logic       done, busy, err;

    i2c_ball_rx_slave_if bus();

    assign bus.i_scl = scl_m;
    assign bus.i_sda = sda_m & ~bus.o_sda_low;

    i2c_ball_rx_slave dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .slv_reg0      (regs_o[0]),
        .slv_reg1      (regs_o[1]),
        .slv_reg2      (regs_o[2]),
        .slv_reg3      (regs_o[3]),
        .slv_reg4      (regs_o[4]),
        .slv_reg5      (regs_o[5]),
        .is_slave_done (done),
        .o_busy        (busy),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    int done_cnt = 0;
    int err_cnt  = 0;
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
    end

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_regs [6];
    logic [7:0] m_shadow [6];
    bit         m_open, m_addr_ok;
    int         m_n, exp_done, exp_err;
    logic [7:0] pkt [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic wq();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 6; i++) chk($sformatf("%s_reg%0d", tag, i), 32'(regs_o[i]), 32'(exp_regs[i]));
        chk({tag, "_done_cnt"}, done_cnt, exp_done);
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_sda_low"}, 32'(bus.o_sda_low), 0);
    endtask

    task automatic i2c_start();
        if (m_open && m_addr_ok && m_n > 0) exp_err++;
        m_open = 1; m_addr_ok = 0; m_n = 0;
        sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); sda_m = 1'b0; wq(); scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        if (m_open && m_addr_ok) begin
            if (m_n == 6) begin
                exp_regs = m_shadow;
                exp_done++;
            end else begin
                exp_err++;
            end
        end
        m_open = 0;
        sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq(); wq();
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack, output bit leaked);
        leaked = 0;
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wq(); scl_m = 1'b1; wq();
            if (bus.o_sda_low) leaked = 1;
            wq(); scl_m = 1'b0; wq();
        end
        sda_m = 1'b1; wq(); scl_m = 1'b1; wq();
        ack = ~bus.i_sda;
        wq(); scl_m = 1'b0; wq();
    endtask

    task automatic addr_phase(input logic [7:0] a);
        bit ack, leaked;
        m_addr_ok = (a == ADDR_W);
        send_byte(a, ack, leaked);
        chk($sformatf("addr_ack_%02h", a), 32'(ack), 32'(m_addr_ok));
        chk("addr_sda_leak", 32'(leaked), 0);
        chk($sformatf("addr_busy_%02h", a), 32'(busy), 32'(m_addr_ok));
    endtask

    task automatic data_phase(input logic [7:0] b);
        bit ack, leaked, want;
        want = m_addr_ok && (m_n < 6);
        if (want) m_shadow[m_n] = b;
        m_n++;
        send_byte(b, ack, leaked);
        chk($sformatf("data_ack_%0d", m_n), 32'(ack), 32'(want));
        chk("data_sda_leak", 32'(leaked), 0);
    endtask

    task automatic run_packet(input logic [7:0] a, input bit do_stop, input string tag);
        i2c_start();
        addr_phase(a);
        foreach (pkt[i]) data_phase(pkt[i]);
        if (do_stop) begin
            i2c_stop();
            check_outputs(tag);
        end
    endtask

    task automatic fill_random(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] addr_pick [5];
        addr_pick = '{8'h84, 8'h86, 8'h85, 8'h84, 8'h84};
        exp_regs = '{default: '0};
        m_shadow = '{default: '0};
        m_open = 0; m_addr_ok = 0; m_n = 0; exp_done = 0; exp_err = 0;

        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        wq();
        check_outputs("reset");

        pkt = '{8'h10, 8'h20, 8'h05, 8'h01, 8'h03, 8'h00};
        run_packet(ADDR_W, 1, "good");

        fill_random(6);
        run_packet(8'h86, 1, "wrong_addr");
        fill_random(6);
        run_packet(8'h85, 1, "read_req");

        fill_random(4);
        run_packet(ADDR_W, 1, "short");

        fill_random(7);
        run_packet(ADDR_W, 1, "overlong");

        fill_random(2);
        run_packet(ADDR_W, 0, "restart_a");
        pkt = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
        run_packet(ADDR_W, 1, "restart_b");

        // Reset part-way through the third data byte.
        fill_random(2);
        run_packet(ADDR_W, 0, "pre_reset");
        b = 8'($urandom_range(0, 255));
        for (int i = 7; i >= 4; i--) begin
            sda_m = b[i]; wq(); scl_m = 1'b1; wq(); wq(); scl_m = 1'b0; wq();
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m_open = 0;
        exp_regs = '{default: '0};
        check_outputs("mid_reset");
        i2c_stop();
        check_outputs("post_reset_stop");
        fill_random(6);
        run_packet(ADDR_W, 1, "after_reset");

        for (int k = 0; k < 12; k++) begin
            int  len;
            bit  stop_it;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 6;
            stop_it = (k == 11) || ($urandom_range(0, 3) != 0);
            fill_random(len);
            run_packet(addr_pick[$urandom_range(0, 4)], stop_it, $sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
